// File: rtl/brightness_scaler_pkg.sv
// Shared definitions for the brightness scaler.
//   state_t    : FSM state encodings (IDLE -> MUL_R -> MUL_G -> MUL_B -> OUT)
//   GAIN_ONE   : unity gain in unsigned Q8.8, also the reset value of the gain register
//   ROUND_HALF : half-LSB added before the >>8 so results round half-up
//   SAT_MAX    : value a channel clamps to when the scaled result exceeds 8 bits
package brightness_scaler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL_R = 3'd1,
        ST_MUL_G = 3'd2,
        ST_MUL_B = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    localparam logic [15:0] GAIN_ONE   = 16'h0100;
    localparam logic [31:0] ROUND_HALF = 32'h0000_0080;
    localparam logic [7:0]  SAT_MAX    = 8'hFF;

endpackage

// File: rtl/MUL_16bit.sv
// Unsigned 16x16 -> 32 combinational multiplier, shared across the colour
// channels by the brightness scaler.
//   a, b : unsigned operands
//   p    : full-width product
module MUL_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    assign p = 32'(a) * 32'(b);

endmodule

// File: rtl/brightness_scaler.sv
// RGB888 brightness scaler with an unsigned Q8.8 gain.
// One pixel at a time: accept in IDLE, multiply R, G, B in three consecutive
// cycles through one shared multiplier, then present the result in OUT until
// the downstream handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   gain_load, gain_in  : write port of the gain register (any state)
//   bypass              : captured at accept; pass the pixel unscaled
//   s_valid/s_ready     : input handshake; s_pixel {R,G,B}, s_sof, s_eol
//   m_valid/m_ready     : output handshake; m_pixel {R,G,B}, m_sof, m_eol
module brightness_scaler
    import brightness_scaler_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gain_load,
    input  logic [15:0] gain_in,
    input  logic        bypass,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_pixel,
    input  logic        s_sof,
    input  logic        s_eol,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [23:0] m_pixel,
    output logic        m_sof,
    output logic        m_eol
);

    state_t      state, state_nxt;
    logic [15:0] gain_q;
    logic [15:0] cap_gain;
    logic [23:0] cap_pixel;
    logic        cap_sof, cap_eol, cap_bypass;
    logic [7:0]  r_q, g_q, b_q;

    logic        accept;
    logic [7:0]  chan;
    logic [31:0] prod;
    logic [31:0] rnd;
    logic [7:0]  res;

    assign s_ready = (state == ST_IDLE);
    assign m_valid = (state == ST_OUT);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (s_valid) state_nxt = ST_MUL_R;
            ST_MUL_R: state_nxt = ST_MUL_G;
            ST_MUL_G: state_nxt = ST_MUL_B;
            ST_MUL_B: state_nxt = ST_OUT;
            ST_OUT:   if (m_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // The gain register follows gain_load in every state; the pixel in flight
    // works from its own captured copy, so mid-pixel loads never disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         gain_q <= GAIN_ONE;
        else if (gain_load) gain_q <= gain_in;
    end

    // A load in the accept cycle applies to that very pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_gain   <= GAIN_ONE;
            cap_pixel  <= '0;
            cap_sof    <= 1'b0;
            cap_eol    <= 1'b0;
            cap_bypass <= 1'b0;
        end else if (accept) begin
            cap_gain   <= gain_load ? gain_in : gain_q;
            cap_pixel  <= s_pixel;
            cap_sof    <= s_sof;
            cap_eol    <= s_eol;
            cap_bypass <= bypass;
        end
    end

    // Channel steering into the shared multiplier.
    always_comb begin
        chan = 8'h00;
        case (state)
            ST_MUL_R: chan = cap_pixel[23:16];
            ST_MUL_G: chan = cap_pixel[15:8];
            ST_MUL_B: chan = cap_pixel[7:0];
            default:  chan = 8'h00;
        endcase
    end

    MUL_16bit u_mul (
        .a (16'(chan)),
        .b (cap_gain),
        .p (prod)
    );

    // Max product is 255*0xFFFF < 2^24, so adding the half-LSB cannot wrap.
    assign rnd = (prod + ROUND_HALF) >> 8;
    assign res = (rnd > 32'd255) ? SAT_MAX : rnd[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else begin
            case (state)
                ST_MUL_R: r_q <= res;
                ST_MUL_G: g_q <= res;
                ST_MUL_B: b_q <= res;
                default: ;
            endcase
        end
    end

    // Everything feeding the outputs changes only at accept or in the MUL
    // states, so the output is naturally held while OUT waits for m_ready.
    assign m_pixel = cap_bypass ? cap_pixel : {r_q, g_q, b_q};
    assign m_sof   = cap_sof;
    assign m_eol   = cap_eol;

endmodule

// File: tb/tb_brightness_scaler.sv
module tb_brightness_scaler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gain_load;
    logic [15:0] gain_in;
    logic        bypass;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_pixel;
    logic        s_sof, s_eol;
    logic        m_valid;
    logic        m_ready;
    logic [23:0] m_pixel;
    logic        m_sof, m_eol;

    int checks = 0;
    int errors = 0;
    logic [15:0] model_gain;

    always #5 clk = ~clk;

    brightness_scaler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gain_load (gain_load),
        .gain_in   (gain_in),
        .bypass    (bypass),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_pixel   (s_pixel),
        .s_sof     (s_sof),
        .s_eol     (s_eol),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_pixel   (m_pixel),
        .m_sof     (m_sof),
        .m_eol     (m_eol)
    );

    typedef struct {
        logic [1:0]  mode;   // 0: preload register, 1: load in accept cycle, 2: use register
        logic [15:0] gain;
        logic        byp;
        logic [23:0] px;
        logic        sof;
        logic        eol;
        int          hold;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: each channel is c*gain/256 rounded half-up, clamped to 255.
    function automatic logic [23:0] model(input logic [15:0] g, input logic byp, input logic [23:0] px);
        logic [23:0] o;
        longint v, r;
        if (byp) return px;
        o = '0;
        for (int c = 0; c < 3; c++) begin
            v = longint'(px[8*c +: 8]);
            r = (v * longint'(g) + 128) / 256;
            if (r > 255) r = 255;
            o[8*c +: 8] = 8'(r);
        end
        return o;
    endfunction

    // Entered and left at posedge+1.
    task automatic run_pixel(input string nm, input logic [1:0] mode, input logic [15:0] g,
                             input logic byp, input logic [23:0] px, input logic sof,
                             input logic eol, input int hold, input logic ld,
                             input logic [15:0] ld_g, input logic [23:0] exp);
        int n;
        if (mode == 2'd0) begin
            gain_load = 1'b1; gain_in = g;
            @(posedge clk); #1;
            gain_load = 1'b0;
            model_gain = g;
        end
        s_valid = 1'b1; s_pixel = px; s_sof = sof; s_eol = eol; bypass = byp;
        gain_load = (mode == 2'd1); gain_in = g;
        n = 0;
        while (!s_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!s_ready) check({nm, "_ready_timeout"}, 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0; gain_load = 1'b0; bypass = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
        if (mode == 2'd1) model_gain = g;
        check({nm, "_busy"}, 32'(s_ready), 32'd0);
        if (ld) begin
            gain_load = 1'b1; gain_in = ld_g; model_gain = ld_g;
        end
        // m_valid rises on the 4th edge counting the accept edge.
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            gain_load = 1'b0;
            check({nm, "_mvalid"}, 32'(m_valid), (k == 3) ? 32'd1 : 32'd0);
        end
        check({nm, "_pixel"}, 32'(m_pixel), 32'(exp));
        check({nm, "_side"}, {30'd0, m_sof, m_eol}, {30'd0, sof, eol});
        for (int h = 0; h < hold; h++) begin
            if (ld) begin gain_load = 1'b1; gain_in = ld_g ^ 16'h5A5A; model_gain = gain_in; end
            @(posedge clk); #1;
            gain_load = 1'b0;
            check({nm, "_hold"}, {6'd0, m_valid, s_ready, m_pixel}, {6'd0, 1'b1, 1'b0, exp});
            check({nm, "_hold_side"}, {30'd0, m_sof, m_eol}, {30'd0, sof, eol});
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check({nm, "_done"}, {30'd0, m_valid, s_ready}, {30'd0, 1'b0, 1'b1});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  mode;
        logic [15:0] g, eff, ldg;
        logic        byp, ld;
        logic [23:0] px;
        int          hold, seen;

        rst_n = 1'b0; gain_load = 1'b0; gain_in = '0; bypass = 1'b0;
        s_valid = 1'b1; s_pixel = 24'hABCDEF; s_sof = 1'b0; s_eol = 1'b0; m_ready = 1'b0;
        model_gain = 16'h0100;

        // Reset state, with s_valid high to show no accept happens in reset.
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {m_valid, m_sof, m_eol, m_pixel}, 27'd0);
        check("rst_sready", 32'(s_ready), 32'd1);
        s_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_no_accept", {31'd0, m_valid}, 32'd0);
        check("post_rst_idle", 32'(s_ready), 32'd1);

        tbl[0] = '{2'd2, 16'h0000, 1'b0, 24'h804020, 1'b1, 1'b0, 0, 24'h804020};
        tbl[1] = '{2'd0, 16'h0180, 1'b0, 24'hFF0201, 1'b0, 1'b0, 1, 24'hFF0302};
        tbl[2] = '{2'd0, 16'h0000, 1'b0, 24'h123456, 1'b0, 1'b1, 0, 24'h000000};
        tbl[3] = '{2'd0, 16'h0001, 1'b0, 24'h808080, 1'b1, 1'b1, 0, 24'h010101};
        tbl[4] = '{2'd1, 16'h0200, 1'b0, 24'h101010, 1'b0, 1'b0, 0, 24'h202020};
        tbl[5] = '{2'd2, 16'h0000, 1'b1, 24'h101010, 1'b0, 1'b0, 0, 24'h101010};
        tbl[6] = '{2'd1, 16'hFFFF, 1'b0, 24'h01FF00, 1'b0, 1'b1, 2, 24'hFFFF00};
        tbl[7] = '{2'd0, 16'h0100, 1'b0, 24'hA5015A, 1'b0, 1'b1, 0, 24'hA5015A};
        for (int i = 0; i < 8; i++)
            run_pixel($sformatf("vec%0d", i), tbl[i].mode, tbl[i].gain, tbl[i].byp, tbl[i].px,
                      tbl[i].sof, tbl[i].eol, tbl[i].hold, 1'b0, 16'h0, tbl[i].exp);

        // Long stall with gain loads landing in the window; result must not move.
        run_pixel("stall", 2'd0, 16'h0180, 1'b0, 24'h102030, 1'b1, 1'b1, 6, 1'b1, 16'h0000,
                  24'h183048);
        // The last stall-window load sticks in the register for the next pixel.
        run_pixel("after_stall", 2'd2, 16'h0, 1'b0, 24'h405060, 1'b0, 1'b0, 0, 1'b0, 16'h0,
                  model(model_gain, 1'b0, 24'h405060));

        // Reset while the G channel is being multiplied.
        gain_load = 1'b1; gain_in = 16'h0300;
        @(posedge clk); #1;
        gain_load = 1'b0;
        s_valid = 1'b1; s_pixel = 24'h404040;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_sready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_gain = 16'h0100;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (m_valid) seen++;
        end
        check("midrst_no_emit", 32'(seen), 32'd0);
        run_pixel("midrst_next", 2'd2, 16'h0, 1'b0, 24'h112233, 1'b0, 1'b1, 0, 1'b0, 16'h0,
                  24'h112233);

        // Randomized pixels against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            mode = 2'($urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0:       g = 16'h0100;
                1:       g = 16'($urandom);
                2:       g = 16'($urandom) & 16'h03FF;
                default: g = 16'($urandom_range(0, 2));
            endcase
            byp  = ($urandom_range(0, 7) == 0);
            px   = 24'($urandom);
            hold = $urandom_range(0, 3);
            ld   = ($urandom_range(0, 3) == 0);
            ldg  = 16'($urandom);
            eff  = (mode == 2'd2) ? model_gain : g;
            run_pixel($sformatf("rnd%0d", i), mode, g, byp, px, px[0], px[1], hold, ld, ldg,
                      model(eff, byp, px));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
